cache_miss_arbiter: RTL

//  Sits between core_top miss ports (icache/dcache) and the main-memory model.

---
 rtl/cache_miss_arbiter_if.sv | 75 +++++++
 rtl/cache_miss_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_miss_arbiter_if
// Description : Bundle of the cache-miss request, response and main-memory
//               handshake signals seen by cache_miss_arbiter.
//               slave  = arbiter view, master = cache/memory environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_miss_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int LINE_W = 128
);
    // Miss info layout: {addr, is_store, data}
    localparam int INFO_W = ADDR_W + 1 + LINE_W;

    // Cache miss requests
    logic                dcache_req_valid_miss;
    logic [INFO_W-1:0]   dcache_req_info_miss;
    logic                icache_req_valid_miss;
    logic [INFO_W-1:0]   icache_req_info_miss;

    // Response back to the caches
    logic                rsp_valid_miss;
    logic                rsp_cache_id;
    logic [LINE_W-1:0]   rsp_data_miss;
    logic                rsp_bus_error;

    // Main-memory request channel
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_req_we;
    logic [LINE_W-1:0]   mem_req_data;

    // Main-memory completion channel
    logic                mem_rsp_valid;
    logic [LINE_W-1:0]   mem_rsp_data;

    modport slave (
        input  dcache_req_valid_miss,
        input  dcache_req_info_miss,
        input  icache_req_valid_miss,
        input  icache_req_info_miss,
        output rsp_valid_miss,
        output rsp_cache_id,
        output rsp_data_miss,
        output rsp_bus_error,
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_addr,
        output mem_req_we,
        output mem_req_data,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport master (
        output dcache_req_valid_miss,
        output dcache_req_info_miss,
        output icache_req_valid_miss,
        output icache_req_info_miss,
        input  rsp_valid_miss,
        input  rsp_cache_id,
        input  rsp_data_miss,
        input  rsp_bus_error,
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_addr,
        input  mem_req_we,
        input  mem_req_data,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/cache_miss_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_miss_arbiter
// Description : Captures single-cycle miss pulses from the icache and dcache,
//               arbitrates round-robin between them, issues one line
//               transaction at a time to main memory and routes the result
//               back. Out-of-range lines and memory timeouts return a bus
//               error without (further) memory involvement.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_miss_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int LINE_W     = 128,
    parameter int ADDR_LIMIT = 16000,
    parameter int TIMEOUT    = 15
) (
    input  wire                   clk_i,
    input  wire                   reset_i,
    cache_miss_arbiter_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_info_w   = ADDR_W + 1 + LINE_W;
    localparam int c_we_bit   = LINE_W;
    localparam int c_addr_lsb = LINE_W + 1;

    localparam logic c_id_icache = 1'b0;
    localparam logic c_id_dcache = 1'b1;

    localparam logic [ADDR_W-1:0] c_addr_limit = ADDR_W'(ADDR_LIMIT);
    localparam logic [3:0]        c_timeout    = 4'(TIMEOUT);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]                 state_q,      state_d;
    logic [1:0]                 slot_valid_q, slot_valid_d;   // [1]=dcache [0]=icache
    logic [1:0][c_info_w-1:0]   slot_info_q,  slot_info_d;
    logic                       rr_last_q,    rr_last_d;
    logic                       issue_id_q,   issue_id_d;
    logic [ADDR_W-1:0]          issue_addr_q, issue_addr_d;
    logic                       issue_we_q,   issue_we_d;
    logic [LINE_W-1:0]          issue_data_q, issue_data_d;
    logic [LINE_W-1:0]          rsp_data_q,   rsp_data_d;
    logic                       err_q,        err_d;
    logic [3:0]                 tmo_cnt_q,    tmo_cnt_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [1:0]                 w_pulse;
    logic [1:0][c_info_w-1:0]   w_info;
    logic [1:0]                 w_clear;
    logic                       w_in_issue;
    logic                       w_in_resp;
    logic                       w_out_of_range;
    logic                       w_grant_id;
    logic [c_info_w-1:0]        w_grant_info;
    logic [3:0]                 w_tmo_next;
    logic                       w_mem_req_valid;

    assign w_pulse = {bus.dcache_req_valid_miss, bus.icache_req_valid_miss};

    // The icache never stores, so its is_store bit is forced low on capture.
    assign w_info[1] = bus.dcache_req_info_miss;
    assign w_info[0] = {bus.icache_req_info_miss[c_info_w-1:c_addr_lsb],
                        1'b0,
                        bus.icache_req_info_miss[LINE_W-1:0]};

    assign w_in_issue     = (state_q == c_st_issue);
    assign w_in_resp      = (state_q == c_st_resp);
    assign w_out_of_range = (issue_addr_q >= c_addr_limit);
    assign w_tmo_next     = tmo_cnt_q + 4'd1;

    // The winner's slot is released in the response cycle.
    assign w_clear = w_in_resp ? ((issue_id_q == c_id_dcache) ? 2'b10 : 2'b01)
                               : 2'b00;

    // Round robin: with both pending, the cache not served last wins.
    assign w_grant_id   = (&slot_valid_q) ? ~rr_last_q : slot_valid_q[1];
    assign w_grant_info = slot_info_q[w_grant_id];

    // ------------------------------------------------------------------------
    // Outputs: all driven from registered state so they are glitch-free and
    // hold steady while memory back-pressures the request.
    // ------------------------------------------------------------------------
    assign w_mem_req_valid   = w_in_issue && !w_out_of_range;

    assign bus.mem_req_valid  = w_mem_req_valid;
    assign bus.mem_req_addr   = w_mem_req_valid ? issue_addr_q : '0;
    assign bus.mem_req_we     = w_mem_req_valid ? issue_we_q   : 1'b0;
    assign bus.mem_req_data   = w_mem_req_valid ? issue_data_q : '0;

    assign bus.rsp_valid_miss = w_in_resp;
    assign bus.rsp_cache_id   = w_in_resp ? issue_id_q : 1'b0;
    assign bus.rsp_data_miss  = w_in_resp ? rsp_data_q : '0;
    assign bus.rsp_bus_error  = w_in_resp ? err_q      : 1'b0;

    // Pending slot update: a pulse fills an empty slot, or refills one that
    // is being released this very cycle; a pulse on a busy slot is dropped.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_info_d  = slot_info_q;
        for (int i = 0; i < 2; i++) begin
            if (w_clear[i]) begin
                slot_valid_d[i] = 1'b0;
            end
            if (w_pulse[i] && (!slot_valid_q[i] || w_clear[i])) begin
                slot_valid_d[i] = 1'b1;
                slot_info_d[i]  = w_info[i];
            end
        end
    end

    // Transaction FSM: grant, issue to memory, wait for completion, respond.
    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        issue_id_d   = issue_id_q;
        issue_addr_d = issue_addr_q;
        issue_we_d   = issue_we_q;
        issue_data_d = issue_data_q;
        rsp_data_d   = rsp_data_q;
        err_d        = err_q;
        tmo_cnt_d    = tmo_cnt_q;

        case (state_q)
            c_st_idle: begin
                // Only registered slots compete, so a pulse arriving now
                // waits for the next arbitration.
                if (|slot_valid_q) begin
                    issue_id_d   = w_grant_id;
                    issue_addr_d = w_grant_info[c_info_w-1:c_addr_lsb];
                    issue_we_d   = w_grant_info[c_we_bit];
                    issue_data_d = w_grant_info[LINE_W-1:0];
                    rsp_data_d   = '0;
                    err_d        = 1'b0;
                    state_d      = c_st_issue;
                end
            end

            c_st_issue: begin
                if (w_out_of_range) begin
                    // Illegal line: answer with an error, memory untouched.
                    err_d   = 1'b1;
                    state_d = c_st_resp;
                end else if (bus.mem_req_ready) begin
                    tmo_cnt_d = '0;
                    state_d   = c_st_wait;
                end
            end

            c_st_wait: begin
                // A completion in the last allowed cycle still wins over
                // the timeout.
                if (bus.mem_rsp_valid) begin
                    rsp_data_d = issue_we_q ? '0 : bus.mem_rsp_data;
                    state_d    = c_st_resp;
                end else if (w_tmo_next == c_timeout) begin
                    err_d   = 1'b1;
                    state_d = c_st_resp;
                end else begin
                    tmo_cnt_d = w_tmo_next;
                end
            end

            c_st_resp: begin
                rr_last_d = issue_id_q;
                state_d   = c_st_idle;
            end

            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Register update with synchronous reset; rr_last starts on the icache
    // so a simultaneous first request favours the dcache.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= c_st_idle;
            slot_valid_q <= '0;
            slot_info_q  <= '0;
            rr_last_q    <= c_id_icache;
            issue_id_q   <= c_id_icache;
            issue_addr_q <= '0;
            issue_we_q   <= 1'b0;
            issue_data_q <= '0;
            rsp_data_q   <= '0;
            err_q        <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_info_q  <= slot_info_d;
            rr_last_q    <= rr_last_d;
            issue_id_q   <= issue_id_d;
            issue_addr_q <= issue_addr_d;
            issue_we_q   <= issue_we_d;
            issue_data_q <= issue_data_d;
            rsp_data_q   <= rsp_data_d;
            err_q        <= err_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // A miss pulse must never land on an occupied slot unless that slot is
    // being released in the same cycle.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_overrun
            a_no_overrun : assert property (@(posedge clk_i) disable iff (reset_i)
                !(w_pulse[g] && slot_valid_q[g] && !w_clear[g]));
        end
    endgenerate

endmodule
`default_nettype wire
